// File: rtl/as_pack.sv
// rtl/as_pack.sv - shared widths and arbiter enums for the as_* data-memory path
package as_pack;

  localparam int dmem_addr_width = 10;
  localparam int reg_width       = 64;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_RD_CPU = 2'd1,
    ARB_RD_DMA = 2'd2
  } as_arb_state_t;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } as_arb_owner_t;

endpackage

// File: rtl/as_dmem_arb_sel.sv
// rtl/as_dmem_arb_sel.sv - combinational one-hot grant selector (AS_DMEM_ARB_RR_EN selects round-robin)
module as_dmem_arb_sel
  import as_pack::*;
(
  input  logic rst_i,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic last_grant_i,
  output logic cpu_gnt_o,
  output logic dma_gnt_o
);

`ifdef AS_DMEM_ARB_RR_EN
  // Tie goes to whoever was not granted last; a sole requester always wins.
  always_comb begin
    cpu_gnt_o = 1'b0;
    dma_gnt_o = 1'b0;
    if (!rst_i) begin
      if (cpu_req_i && dma_req_i) begin
        if (last_grant_i == ARB_CPU) dma_gnt_o = 1'b1;
        else                         cpu_gnt_o = 1'b1;
      end else begin
        cpu_gnt_o = cpu_req_i;
        dma_gnt_o = dma_req_i;
      end
    end
  end
`else
  // Fixed priority: the CPU always wins a tie.
  always_comb begin
    cpu_gnt_o = 1'b0;
    dma_gnt_o = 1'b0;
    if (!rst_i) begin
      cpu_gnt_o = cpu_req_i;
      dma_gnt_o = dma_req_i && !cpu_req_i;
    end
  end

  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/as_dmem_arb.sv
// rtl/as_dmem_arb.sv - CPU/DMA arbiter for as_dmem (AS_DMEM_ARB_RR_EN enables round-robin)
module as_dmem_arb
  import as_pack::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cpu_req_i,
  input  logic                       cpu_we_i,
  input  logic [dmem_addr_width-1:0] cpu_addr_i,
  input  logic [6:0]                 cpu_opcode_i,
  input  logic [2:0]                 cpu_func3_i,
  input  logic [reg_width-1:0]       cpu_wdata_i,
  output logic                       cpu_gnt_o,
  output logic                       cpu_rvalid_o,
  output logic [reg_width-1:0]       cpu_rdata_o,
  input  logic                       dma_req_i,
  input  logic                       dma_we_i,
  input  logic [dmem_addr_width-1:0] dma_addr_i,
  input  logic [6:0]                 dma_opcode_i,
  input  logic [2:0]                 dma_func3_i,
  input  logic [reg_width-1:0]       dma_wdata_i,
  output logic                       dma_gnt_o,
  output logic                       dma_rvalid_o,
  output logic [reg_width-1:0]       dma_rdata_o,
  output logic [dmem_addr_width-1:0] mem_addr_o,
  output logic                       mem_wrEn_o,
  output logic                       mem_rdEn_o,
  output logic [6:0]                 mem_opcode_o,
  output logic [2:0]                 mem_func3_o,
  output logic [reg_width-1:0]       mem_data_o,
  input  logic [reg_width-1:0]       mem_data_i
);

  logic          cpu_gnt;
  logic          dma_gnt;
  logic          last_grant;
  as_arb_state_t state_q, state_d;

`ifdef AS_DMEM_ARB_RR_EN
  as_arb_owner_t last_grant_q, last_grant_d;

  // Remember the most recent winner so the next tie goes the other way.
  always_comb begin
    last_grant_d = last_grant_q;
    if (cpu_gnt)      last_grant_d = ARB_CPU;
    else if (dma_gnt) last_grant_d = ARB_DMA;
  end

  // Last-grant register; resets to DMA so the CPU takes the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_grant_q <= ARB_DMA;
    else       last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = ARB_DMA;
`endif

  as_dmem_arb_sel u_sel (
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .dma_req_i    (dma_req_i),
    .last_grant_i (last_grant),
    .cpu_gnt_o    (cpu_gnt),
    .dma_gnt_o    (dma_gnt)
  );

  assign cpu_gnt_o = cpu_gnt;
  assign dma_gnt_o = dma_gnt;

  // Forward the winner's fields to the memory; idle bus is all zeros.
  always_comb begin
    mem_addr_o   = '0;
    mem_wrEn_o   = 1'b0;
    mem_rdEn_o   = 1'b0;
    mem_opcode_o = '0;
    mem_func3_o  = '0;
    mem_data_o   = '0;
    if (cpu_gnt) begin
      mem_addr_o   = cpu_addr_i;
      mem_wrEn_o   = cpu_we_i;
      mem_rdEn_o   = !cpu_we_i;
      mem_opcode_o = cpu_opcode_i;
      mem_func3_o  = cpu_func3_i;
      mem_data_o   = cpu_wdata_i;
    end else if (dma_gnt) begin
      mem_addr_o   = dma_addr_i;
      mem_wrEn_o   = dma_we_i;
      mem_rdEn_o   = !dma_we_i;
      mem_opcode_o = dma_opcode_i;
      mem_func3_o  = dma_func3_i;
      mem_data_o   = dma_wdata_i;
    end
  end

  // Pending-read owner: set by this cycle's load grant, steers next cycle's read data.
  always_comb begin
    state_d      = ARB_IDLE;
    cpu_rvalid_o = 1'b0;
    dma_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    dma_rdata_o  = '0;
    if (cpu_gnt && !cpu_we_i)      state_d = ARB_RD_CPU;
    else if (dma_gnt && !dma_we_i) state_d = ARB_RD_DMA;
    case (state_q)
      ARB_RD_CPU: begin
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o  = mem_data_i;
      end
      ARB_RD_DMA: begin
        dma_rvalid_o = 1'b1;
        dma_rdata_o  = mem_data_i;
      end
      default: ;
    endcase
  end

  // Read-owner state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_as_dmem_arb.sv
// tb/tb_as_dmem_arb.sv - directed table plus randomized reference-model bench for as_dmem_arb
module tb_as_dmem_arb;
  import as_pack::*;

  localparam int AW        = dmem_addr_width;
  localparam int DW        = reg_width;
  localparam int MEM_BYTES = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [6:0]    cpu_op, dma_op, mem_op;
  logic [2:0]    cpu_f3, dma_f3, mem_f3;
  logic [DW-1:0] cpu_wd, dma_wd, mem_dout, mem_din;
  logic          cpu_gnt, dma_gnt, cpu_rv, dma_rv, mem_we, mem_re;
  logic [DW-1:0] cpu_rd, dma_rd;

  always #5 clk = ~clk;

  as_dmem_arb dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_opcode_i(cpu_op),
    .cpu_func3_i(cpu_f3), .cpu_wdata_i(cpu_wd), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rv),
    .cpu_rdata_o(cpu_rd),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_opcode_i(dma_op),
    .dma_func3_i(dma_f3), .dma_wdata_i(dma_wd), .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rv),
    .dma_rdata_o(dma_rd),
    .mem_addr_o(mem_addr), .mem_wrEn_o(mem_we), .mem_rdEn_o(mem_re), .mem_opcode_o(mem_op),
    .mem_func3_o(mem_f3), .mem_data_o(mem_dout), .mem_data_i(mem_din)
  );

  // Stand-in for as_dmem: byte array, registered 8-byte little-endian read.
  logic [7:0]    sim_mem [MEM_BYTES];
  logic [DW-1:0] sim_r;
  logic [DW-1:0] sim_rdata_q = '0;
  assign mem_din = sim_rdata_q;

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < (1 << mem_f3[1:0]); b++)
        sim_mem[(int'(mem_addr) + b) % MEM_BYTES] = mem_dout[8*b +: 8];
    if (mem_re) begin
      for (int b = 0; b < 8; b++) sim_r[8*b +: 8] = sim_mem[(int'(mem_addr) + b) % MEM_BYTES];
      sim_rdata_q <= sim_r;
    end
  end

  // Reference model state.
  logic [7:0]    ref_mem [MEM_BYTES];
  logic          exp_rv_c = 1'b0, exp_rv_d = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  as_arb_owner_t exp_last = ARB_DMA;
  int            pass_cnt = 0, total_cnt = 0;

  function automatic logic [DW-1:0] ref_load(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = ref_mem[(int'(a) + b) % MEM_BYTES];
    return r;
  endfunction

  function automatic void ref_store(input logic [AW-1:0] a, input logic [2:0] f3, input logic [DW-1:0] d);
    for (int b = 0; b < (1 << f3[1:0]); b++) ref_mem[(int'(a) + b) % MEM_BYTES] = d[8*b +: 8];
  endfunction

  typedef struct {
    logic          rst;
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [2:0]    cf;
    logic [DW-1:0] cd;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [2:0]    df;
    logic [DW-1:0] dd;
    logic          has_exp;
    logic          ecg, edg, ecrv, edrv;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic cr, input logic cw, input int ca, input int cf,
                              input logic [DW-1:0] cd, input logic dr, input logic dw, input int da,
                              input int df, input logic [DW-1:0] dd, input logic ecg, input logic edg,
                              input logic ecrv, input logic edrv);
    vec_t v;
    v.rst = r; v.cr = cr; v.cw = cw; v.ca = AW'(ca); v.cf = 3'(cf); v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = AW'(da); v.df = 3'(df); v.dd = dd;
    v.has_exp = 1'b1; v.ecg = ecg; v.edg = edg; v.ecrv = ecrv; v.edrv = edrv;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic run_cycle(input vec_t v, output logic gc, output logic gd);
    logic [AW+DW+11:0] exp_bus;
    @(negedge clk);
    rst = v.rst;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_f3 = v.cf; cpu_wd = v.cd;
    cpu_op = v.cw ? 7'h23 : 7'h03;
    dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_f3 = v.df; dma_wd = v.dd;
    dma_op = v.dw ? 7'h23 : 7'h03;
    #1;
    gc = 1'b0;
    gd = 1'b0;
    if (!v.rst) begin
      if (v.cr && v.dr) begin
`ifdef AS_DMEM_ARB_RR_EN
        gc = (exp_last == ARB_DMA);
        gd = (exp_last == ARB_CPU);
`else
        gc = 1'b1;
`endif
      end else begin
        gc = v.cr;
        gd = v.dr;
      end
    end
    if (gc)      exp_bus = {v.ca, v.cw, !v.cw, cpu_op, v.cf, v.cd};
    else if (gd) exp_bus = {v.da, v.dw, !v.dw, dma_op, v.df, v.dd};
    else         exp_bus = '0;
    check("cpu_gnt", 128'(cpu_gnt), 128'(gc));
    check("dma_gnt", 128'(dma_gnt), 128'(gd));
    check("mem_bus", 128'({mem_addr, mem_we, mem_re, mem_op, mem_f3, mem_dout}), 128'(exp_bus));
    check("cpu_rvalid", 128'(cpu_rv), 128'(exp_rv_c));
    check("dma_rvalid", 128'(dma_rv), 128'(exp_rv_d));
    check("cpu_rdata", 128'(cpu_rd), 128'(exp_rv_c ? exp_rdata : '0));
    check("dma_rdata", 128'(dma_rd), 128'(exp_rv_d ? exp_rdata : '0));
    if (v.has_exp) begin
      check("tbl_cpu_gnt", 128'(cpu_gnt), 128'(v.ecg));
      check("tbl_dma_gnt", 128'(dma_gnt), 128'(v.edg));
      check("tbl_cpu_rvalid", 128'(cpu_rv), 128'(v.ecrv));
      check("tbl_dma_rvalid", 128'(dma_rv), 128'(v.edrv));
    end
    @(posedge clk);
    exp_rv_c = gc && !v.cw;
    exp_rv_d = gd && !v.dw;
    if (gc) begin
      if (v.cw) ref_store(v.ca, v.cf, v.cd);
      else      exp_rdata = ref_load(v.ca);
    end
    if (gd) begin
      if (v.dw) ref_store(v.da, v.df, v.dd);
      else      exp_rdata = ref_load(v.da);
    end
    if (v.rst)   exp_last = ARB_DMA;
    else if (gc) exp_last = ARB_CPU;
    else if (gd) exp_last = ARB_DMA;
  endtask

  vec_t tbl[$];
  vec_t rv;
  logic gc, gd, pc, pd;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      sim_mem[i] = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_op = '0; cpu_f3 = '0; cpu_wd = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_op = '0; dma_f3 = '0; dma_wd = '0;
    @(posedge clk);

    // reset state
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    // CPU load 0x10, data next cycle
    tbl.push_back(mk(0, 1,0,'h10,3,0, 0,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
    // CPU sd to 0x20, DMA load 0x20 the next cycle
    tbl.push_back(mk(0, 1,1,'h20,3,64'hDEAD_BEEF, 0,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 1,0,'h20,3,0, 0,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,1));
    // both request loads for four cycles
`ifdef AS_DMEM_ARB_RR_EN
    tbl.push_back(mk(0, 1,0,'h40,3,0, 1,0,'h48,3,0, 1,0,0,0));
    tbl.push_back(mk(0, 1,0,'h40,3,0, 1,0,'h48,3,0, 0,1,1,0));
    tbl.push_back(mk(0, 1,0,'h40,3,0, 1,0,'h48,3,0, 1,0,0,1));
    tbl.push_back(mk(0, 1,0,'h40,3,0, 1,0,'h48,3,0, 0,1,1,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,1));
`else
    tbl.push_back(mk(0, 1,0,'h40,3,0, 1,0,'h48,3,0, 1,0,0,0));
    tbl.push_back(mk(0, 1,0,'h40,3,0, 1,0,'h48,3,0, 1,0,1,0));
    tbl.push_back(mk(0, 1,0,'h40,3,0, 1,0,'h48,3,0, 1,0,1,0));
    tbl.push_back(mk(0, 1,0,'h40,3,0, 1,0,'h48,3,0, 1,0,1,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
`endif
    // back-to-back CPU ld, DMA ld, CPU sb, then re-read byte lane
    tbl.push_back(mk(0, 1,0,'h0,3,0, 0,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 1,0,'h8,3,0, 0,1,1,0));
    tbl.push_back(mk(0, 1,1,'h3,0,64'hAB, 0,0,0,0,0, 1,0,0,1));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,0,'h0,3,0, 0,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
    // reset in the load-request cycle
    tbl.push_back(mk(1, 1,0,'h10,3,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    // idle
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) run_cycle(tbl[i], gc, gd);

    // Randomized traffic; each requester holds its transaction until the model grants it.
    rv = mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
    rv.has_exp = 1'b0;
    pc = 1'b0;
    pd = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pc && $urandom_range(0, 99) < 45) begin
        pc = 1'b1;
        rv.cw = 1'($urandom_range(0, 1));
        rv.ca = AW'($urandom_range(0, 63));
        rv.cf = 3'($urandom_range(0, 7));
        rv.cd = {$urandom, $urandom};
      end
      if (!pd && $urandom_range(0, 99) < 50) begin
        pd = 1'b1;
        rv.dw = 1'($urandom_range(0, 1));
        rv.da = AW'($urandom_range(0, 63));
        rv.df = 3'($urandom_range(0, 7));
        rv.dd = {$urandom, $urandom};
      end
      rv.cr  = pc;
      rv.dr  = pd;
      rv.rst = ($urandom_range(0, 63) == 0);
      run_cycle(rv, gc, gd);
      if (gc) pc = 1'b0;
      if (gd) pd = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
